// File: rtl/operand_stack.sv
// 8-bit operand stack that sequences an external combinational ALU (2-cycle ALUOP).
// Optional DUP command enabled by defining OPERAND_STACK_DUP_EN.
module operand_stack #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_sel,
    input  logic [7:0] push_data,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    output logic [1:0] alu_sel,
    input  logic [7:0] alu_result,
    output logic [7:0] top,
    output logic [4:0] depth,
    output logic       error
);
    // state | meaning
    // IDLE  | accepting commands; PUSH/POP/DUP complete on the accept edge
    // EXEC  | ALU operands presented; result written back on the exiting edge
    typedef enum logic {IDLE, EXEC} state_t;

    localparam int         AW   = $clog2(DEPTH);
    localparam logic [4:0] FULL = 5'(DEPTH);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_DUP  = 2'b11;
    localparam logic [1:0] SEL_NOT = 2'b11;

    state_t     state_q, state_d;
    logic [4:0] depth_q, depth_d;
    logic       error_q, error_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic [7:0] alu_x_q, alu_x_d;
    logic [7:0] alu_y_q, alu_y_d;
    logic [1:0] alu_sel_q, alu_sel_d;

    logic [7:0]    mem_q [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [7:0]    wr_data;

    logic [AW-1:0] top_idx, below_idx;
    logic [7:0]    top_val, below_val;
    logic          empty, full, has_two;

    assign top_idx   = AW'(depth_q - 5'd1);
    assign below_idx = AW'(depth_q - 5'd2);
    assign empty     = (depth_q == 5'd0);
    assign full      = (depth_q == FULL);
    assign has_two   = (depth_q >= 5'd2);
    assign top_val   = empty ? 8'h00 : mem_q[top_idx];
    assign below_val = mem_q[below_idx];

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        error_d     = error_q;
        cmd_ready_d = 1'b1;
        alu_x_d     = 8'h00;
        alu_y_d     = 8'h00;
        alu_sel_d   = 2'b00;
        wr_en       = 1'b0;
        wr_idx      = AW'(depth_q);
        wr_data     = push_data;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full) begin
                                error_d = 1'b1;
                            end else begin
                                wr_en   = 1'b1;
                                depth_d = depth_q + 5'd1;
                            end
                        end
                        OP_POP: begin
                            if (empty) error_d = 1'b1;
                            else       depth_d = depth_q - 5'd1;
                        end
                        OP_ALU: begin
                            if ((cmd_sel == SEL_NOT) ? empty : !has_two) begin
                                error_d = 1'b1;
                            end else begin
                                state_d     = EXEC;
                                cmd_ready_d = 1'b0;
                                alu_sel_d   = cmd_sel;
                                alu_x_d     = (cmd_sel == SEL_NOT) ? top_val : below_val;
                                alu_y_d     = (cmd_sel == SEL_NOT) ? 8'h00 : top_val;
                            end
                        end
                        OP_DUP: begin
`ifdef OPERAND_STACK_DUP_EN
                            if (empty || full) begin
                                error_d = 1'b1;
                            end else begin
                                wr_en   = 1'b1;
                                wr_data = top_val;
                                depth_d = depth_q + 5'd1;
                            end
`else
                            error_d = 1'b1;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                // Stack is frozen during EXEC, so the latched select decides the write slot.
                state_d = IDLE;
                wr_en   = 1'b1;
                wr_data = alu_result;
                if (alu_sel_q == SEL_NOT) begin
                    wr_idx = top_idx;
                end else begin
                    wr_idx  = below_idx;
                    depth_d = depth_q - 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            depth_q     <= 5'd0;
            error_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            alu_x_q     <= 8'h00;
            alu_y_q     <= 8'h00;
            alu_sel_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            error_q     <= error_d;
            cmd_ready_q <= cmd_ready_d;
            alu_x_q     <= alu_x_d;
            alu_y_q     <= alu_y_d;
            alu_sel_q   <= alu_sel_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_q[wr_idx] <= wr_data;
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign alu_sel   = alu_sel_q;
    assign top       = top_val;
    assign depth     = depth_q;
    assign error     = error_q;
endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: vector table, corner sequences, and
// random commands against a queue-based stack model.
module tb_operand_stack;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [1:0] cmd_sel = 2'b00;
    logic [7:0] push_data = 8'h00;
    logic [7:0] alu_x, alu_y;
    logic [1:0] alu_sel;
    logic [7:0] alu_result;
    logic [7:0] top;
    logic [4:0] depth;
    logic       error;

    int n_chk = 0;
    int n_err = 0;

    operand_stack #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .push_data(push_data),
        .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_result(alu_result),
        .top(top), .depth(depth), .error(error)
    );

    always #5 clk = ~clk;

    // External ALU the stack drives
    always_comb begin
        case (alu_sel)
            2'b00:   alu_result = alu_x + alu_y;
            2'b01:   alu_result = alu_x - alu_y;
            2'b10:   alu_result = alu_x & alu_y;
            default: alu_result = ~alu_x;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ms[$];
    bit         merr;
    logic [1:0] msel;

    task automatic m_reset();
        ms.delete();
        merr = 1'b0;
    endtask

    task automatic m_accept(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data,
                            output bit exec, output logic [7:0] ex, output logic [7:0] ey);
        exec = 1'b0; ex = 8'h00; ey = 8'h00;
        case (op)
            2'd0: if (ms.size() == DEPTH) merr = 1'b1; else ms.push_back(data);
            2'd1: if (ms.size() == 0) merr = 1'b1; else void'(ms.pop_back());
            2'd2: begin
                if ((sel == 2'd3 && ms.size() < 1) || (sel != 2'd3 && ms.size() < 2)) merr = 1'b1;
                else begin
                    exec = 1'b1; msel = sel;
                    ex = (sel == 2'd3) ? ms[ms.size()-1] : ms[ms.size()-2];
                    ey = (sel == 2'd3) ? 8'h00 : ms[ms.size()-1];
                end
            end
            default: begin
`ifdef OPERAND_STACK_DUP_EN
                if (ms.size() == 0 || ms.size() == DEPTH) merr = 1'b1;
                else ms.push_back(ms[ms.size()-1]);
`else
                merr = 1'b1;
`endif
            end
        endcase
    endtask

    task automatic m_finish();
        logic [7:0] a, b, r;
        if (msel == 2'd3) begin
            ms[ms.size()-1] = ~ms[ms.size()-1];
        end else begin
            b = ms.pop_back();
            a = ms.pop_back();
            case (msel)
                2'd0:    r = 8'((int'(a) + int'(b)) % 256);
                2'd1:    r = 8'((int'(a) - int'(b) + 256) % 256);
                default: r = a & b;
            endcase
            ms.push_back(r);
        end
    endtask

    function automatic logic [7:0] m_top();
        return (ms.size() == 0) ? 8'h00 : ms[ms.size()-1];
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; push_data = 8'h77;
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        m_reset();
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data,
                           input bit exec, input bit hold, input bit chk_alu,
                           input logic [7:0] ex, input logic [7:0] ey);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; push_data = data;
        @(negedge clk);
        if (exec) begin
            chk("ready_in_exec", 32'(cmd_ready), 32'd0);
            if (chk_alu) begin
                chk("alu_x", 32'(alu_x), 32'(ex));
                chk("alu_y", 32'(alu_y), 32'(ey));
                chk("alu_sel", 32'(alu_sel), 32'(sel));
            end
            // Offering a PUSH during EXEC must not be taken
            if (hold) begin cmd_op = 2'd0; push_data = 8'hAA; end
            else cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        chk("alu_x_idle", 32'(alu_x), 32'd0);
        chk("alu_y_idle", 32'(alu_y), 32'd0);
        chk("alu_sel_idle", 32'(alu_sel), 32'd0);
    endtask

    task automatic chk_state(input string tag, input logic [4:0] d, input logic [7:0] t, input logic e);
        chk({tag, "_depth"}, 32'(depth), 32'(d));
        chk({tag, "_top"}, 32'(top), 32'(t));
        chk({tag, "_error"}, 32'(error), 32'(e));
    endtask

    typedef struct {
        logic [1:0] op;
        logic [1:0] sel;
        logic [7:0] data;
        logic       exec;
        logic [4:0] d;
        logic [7:0] t;
        logic       e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data,
                                input logic exec, input logic [4:0] d, input logic [7:0] t, input logic e);
        vec_t v;
        v.op = op; v.sel = sel; v.data = data; v.exec = exec; v.d = d; v.t = t; v.e = e;
        return v;
    endfunction

    initial begin
        bit         exec;
        logic [7:0] ex, ey;
        int         r;

        tbl.push_back(mk(2'd0, 2'd0, 8'h05, 1'b0, 5'd1, 8'h05, 1'b0));
        tbl.push_back(mk(2'd0, 2'd0, 8'h03, 1'b0, 5'd2, 8'h03, 1'b0));
        tbl.push_back(mk(2'd2, 2'd0, 8'h00, 1'b1, 5'd1, 8'h08, 1'b0));
        tbl.push_back(mk(2'd0, 2'd0, 8'h02, 1'b0, 5'd2, 8'h02, 1'b0));
        tbl.push_back(mk(2'd0, 2'd0, 8'h05, 1'b0, 5'd3, 8'h05, 1'b0));
        tbl.push_back(mk(2'd2, 2'd1, 8'h00, 1'b1, 5'd2, 8'hFD, 1'b0));
        tbl.push_back(mk(2'd1, 2'd0, 8'h00, 1'b0, 5'd1, 8'h08, 1'b0));
        tbl.push_back(mk(2'd1, 2'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0));
        tbl.push_back(mk(2'd0, 2'd0, 8'hF0, 1'b0, 5'd1, 8'hF0, 1'b0));
        tbl.push_back(mk(2'd2, 2'd3, 8'h00, 1'b1, 5'd1, 8'h0F, 1'b0));
        tbl.push_back(mk(2'd1, 2'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b0));
        tbl.push_back(mk(2'd1, 2'd0, 8'h00, 1'b0, 5'd0, 8'h00, 1'b1));
        tbl.push_back(mk(2'd0, 2'd0, 8'h11, 1'b0, 5'd1, 8'h11, 1'b1));
        tbl.push_back(mk(2'd2, 2'd2, 8'h00, 1'b0, 5'd1, 8'h11, 1'b1));
        tbl.push_back(mk(2'd2, 2'd3, 8'h00, 1'b1, 5'd1, 8'hEE, 1'b1));
`ifdef OPERAND_STACK_DUP_EN
        tbl.push_back(mk(2'd3, 2'd0, 8'h00, 1'b0, 5'd2, 8'hEE, 1'b1));
        tbl.push_back(mk(2'd2, 2'd0, 8'h00, 1'b1, 5'd1, 8'hDC, 1'b1));
`else
        tbl.push_back(mk(2'd3, 2'd0, 8'h00, 1'b0, 5'd1, 8'hEE, 1'b1));
        tbl.push_back(mk(2'd2, 2'd0, 8'h00, 1'b0, 5'd1, 8'hEE, 1'b1));
`endif

        // reset state, with a PUSH offered during reset
        do_reset();
        chk_state("reset", 5'd0, 8'h00, 1'b0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_alu_x", 32'(alu_x), 32'd0);
        chk("reset_alu_sel", 32'(alu_sel), 32'd0);

        foreach (tbl[i]) begin
            run_cmd(tbl[i].op, tbl[i].sel, tbl[i].data, tbl[i].exec, 1'b0, 1'b0, 8'h00, 8'h00);
            chk_state($sformatf("vec%0d", i), tbl[i].d, tbl[i].t, tbl[i].e);
        end

        // SUB operand presentation and one-cycle busy window
        do_reset();
        run_cmd(2'd0, 2'd0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_cmd(2'd0, 2'd0, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_cmd(2'd2, 2'd1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 8'h05);
        chk_state("sub", 5'd1, 8'hFD, 1'b0);

        // overflow at full depth
        do_reset();
        for (int i = 1; i <= 9; i++)
            run_cmd(2'd0, 2'd0, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk_state("full", 5'd8, 8'h08, 1'b1);
        run_cmd(2'd1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk_state("full_pop", 5'd7, 8'h07, 1'b1);

        // reset during EXEC aborts write-back
        do_reset();
        run_cmd(2'd0, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        run_cmd(2'd0, 2'd0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_sel = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_busy", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_state("abort", 5'd0, 8'h00, 1'b0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_alu_x", 32'(alu_x), 32'd0);
        @(negedge clk);
        chk_state("abort_after", 5'd0, 8'h00, 1'b0);

        // randomized commands against the model
        for (int burst = 0; burst < 2; burst++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                logic [1:0] op, sel;
                logic [7:0] data;
                bit         hold;
                r = $urandom_range(0, 9);
                op = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                sel  = 2'($urandom_range(0, 3));
                data = 8'($urandom);
                hold = ($urandom_range(0, 3) == 0);
                m_accept(op, sel, data, exec, ex, ey);
                run_cmd(op, sel, data, exec, hold, 1'b1, ex, ey);
                if (exec) m_finish();
                chk_state("rand", 5'(ms.size()), m_top(), merr);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
